// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundling decode control, instruction memory and IF/ID outputs
interface fetch_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             PCsrc;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] RD;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] instr_D;
  logic [WIDTH-1:0] PC_D;
  logic             valid_D;
  logic             fetch_err;
  logic [WIDTH-1:0] fetch_count;
  modport master (
    input  stall, PCsrc, ImmOp, RD,
    output PC, instr_D, PC_D, valid_D, fetch_err, fetch_count
  );
  modport slave (
    output stall, PCsrc, ImmOp, RD,
    input  PC, instr_D, PC_D, valid_D, fetch_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, IF/ID register and branch redirect with one-bubble flush
module fetch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pcd_q, pcd_d, cnt_q, cnt_d, target;
  logic             valid_q, valid_d, err_q, err_d, redirect;
  // valid_q doubles as the RUN/BUBBLE state: a bubble can never redirect
  assign redirect = bus.PCsrc & valid_q & ~bus.stall;
  assign target   = pcd_q + bus.ImmOp;
  always_comb begin
    pc_d    = bus.stall ? pc_q : redirect ? {target[WIDTH-1:2], 2'b00} : pc_q + WIDTH'(4);
    instr_d = bus.stall ? instr_q : redirect ? NOP_INSTR : bus.RD;
    pcd_d   = bus.stall ? pcd_q : pc_q;
    valid_d = bus.stall ? valid_q : ~redirect;
    err_d   = err_q | (redirect & |target[1:0]);
    cnt_d   = (bus.stall | redirect) ? cnt_q : cnt_q + WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.PC          = pc_q;
  assign bus.instr_D     = instr_q;
  assign bus.PC_D        = pcd_q;
  assign bus.valid_D     = valid_q;
  assign bus.fetch_err   = err_q;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench; stimulus queues expected state, monitor checks after each edge
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  typedef struct {
    logic [31:0] pc, instr, pcd, cnt;
    logic        valid, err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  fetch_if #(.WIDTH(32)) bus();
  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.RD = bus.PC ^ KEY;
  function automatic logic [31:0] x(input logic [31:0] a);
    return a ^ KEY;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h (check %0d)", n, a, e, total);
  endtask
  task automatic s(input logic r, input logic st, input logic br, input logic [31:0] imm,
                   input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] pcd,
                   input logic v, input logic e, input logic [31:0] c);
    exp_t t;
    @(negedge clk);
    rst       = r;
    bus.stall = st;
    bus.PCsrc = br;
    bus.ImmOp = imm;
    t.pc = pc; t.instr = ins; t.pcd = pcd; t.valid = v; t.err = e; t.cnt = c;
    sb.push_back(t);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        exp_t t;
        t = sb.pop_front();
        chk("PC", bus.PC, t.pc);
        chk("instr_D", bus.instr_D, t.instr);
        chk("PC_D", bus.PC_D, t.pcd);
        chk("valid_D", 32'(bus.valid_D), 32'(t.valid));
        chk("fetch_err", 32'(bus.fetch_err), 32'(t.err));
        chk("fetch_count", bus.fetch_count, t.cnt);
      end
    end
  end
  initial begin
    bus.stall = 1'b0;
    bus.PCsrc = 1'b0;
    bus.ImmOp = '0;
    s(1, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    s(0, 0, 0, 0, 4, x(0), 0, 1, 0, 1);
    s(0, 0, 0, 0, 8, x(4), 4, 1, 0, 2);
    s(0, 0, 0, 0, 12, x(8), 8, 1, 0, 3);
    s(0, 0, 1, -32'sd8, 0, NOP, 12, 0, 0, 3);
    s(0, 0, 1, -32'sd8, 4, x(0), 0, 1, 0, 4);
    s(0, 0, 0, 0, 8, x(4), 4, 1, 0, 5);
    s(0, 0, 0, 0, 12, x(8), 8, 1, 0, 6);
    s(0, 0, 0, 0, 16, x(12), 12, 1, 0, 7);
    for (int i = 0; i < 3; i++) s(0, 1, 1, 8, 16, x(12), 12, 1, 0, 7);
    s(0, 0, 1, 8, 20, NOP, 16, 0, 0, 7);
    s(0, 0, 0, 0, 24, x(20), 20, 1, 0, 8);
    s(0, 0, 1, -32'sd16, 4, NOP, 24, 0, 0, 8);
    s(0, 0, 0, 0, 8, x(4), 4, 1, 0, 9);
    s(0, 0, 1, 6, 8, NOP, 8, 0, 1, 9);
    for (int k = 1; k <= 10; k++)
      s(0, 0, 0, 0, 8 + 4 * k, x(4 + 4 * k), 4 + 4 * k, 1, 1, 9 + k);
    s(1, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    s(0, 0, 0, 0, 4, x(0), 0, 1, 0, 1);
    s(0, 0, 0, 0, 8, x(4), 4, 1, 0, 2);
    s(0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, NOP, 8, 0, 0, 2);
    s(0, 0, 0, 0, 0, x(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 0, 3);
    s(0, 0, 0, 0, 4, x(0), 0, 1, 0, 4);
    s(1, 0, 1, 100, 0, NOP, 0, 0, 0, 0);
    s(0, 0, 0, 0, 4, x(0), 0, 1, 0, 1);
    s(1, 1, 0, 0, 0, NOP, 0, 0, 0, 0);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL drain: %0d entries left, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Upstream neighbour of the instruction memory, control unit and sign-extend group.
- Owns the program counter and presents `PC` to instruction memory.
- Registers the returned instruction into an IF/ID pipeline register for decode.
- Resolves branch redirects using `PCsrc` and `ImmOp`, which decode computes from the registered instruction.

Parameters:
- WIDTH, 32, datapath and address width in bits.
- RESET_PC, 0, `PC` value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction placed in `instr_D` on reset and flush.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  freezes `PC`, the IF/ID register and the counter.
- PCsrc  input  1  branch taken, from decode; qualified by `valid_D`.
- ImmOp  input  WIDTH  sign-extended branch offset, from decode.
- RD  input  WIDTH  instruction word from instruction memory; combinational in `PC`.
- PC  output  WIDTH  current fetch address to instruction memory.
- instr_D  output  WIDTH  registered instruction for decode.
- PC_D  output  WIDTH  address of `instr_D`.
- valid_D  output  1  `instr_D` is a real instruction, not a bubble.
- fetch_err  output  1  sticky flag: a misaligned branch target was seen.
- fetch_count  output  WIDTH  count of instructions delivered to decode.

Behaviour:
- Reset (`rst`=1 at a rising edge) takes priority over everything, including mid-stall and mid-redirect. It sets:
  - `PC`=RESET_PC
  - `instr_D`=NOP_INSTR
  - `PC_D`=0
  - `valid_D`=0
  - `fetch_err`=0
  - `fetch_count`=0
- Latency:
  - `RD` sampled in cycle N appears on `instr_D` in cycle N+1.
  - `PC_D` equals the `PC` of cycle N.
- `redirect` = `PCsrc` & `valid_D` & !`stall`.
- `target` = `PC_D` + `ImmOp`, computed modulo 2^WIDTH.
- Priority per cycle when not in reset:
  1. stall=1: every register holds. `PCsrc` is ignored, and decode re-presents it on the next cycle.
  2. redirect=1:
     - `PC` <= {`target`[WIDTH-1:2], 2'b00}.
     - `instr_D` <= NOP_INSTR, `valid_D` <= 0; the wrong-path fetch is flushed.
     - `PC_D` <= `PC`; the value is don't-care but defined.
     - If `target`[1:0] != 0, `fetch_err` <= 1.
     - `fetch_count` unchanged.
  3. Otherwise:
     - `PC` <= `PC` + 4, wrapping modulo 2^WIDTH, so all-ones-minus-3 wraps to 0.
     - `instr_D` <= `RD`, `PC_D` <= `PC`, `valid_D` <= 1.
     - `fetch_count` <= `fetch_count` + 1, wrapping from all-ones to 0.
- `PCsrc` while `valid_D`=0 is ignored. A bubble can never branch, so there is no double redirect on back-to-back `PCsrc`.
- Redirect penalty is exactly one bubble cycle. After a redirect `valid_D`=0 for one cycle, then the target instruction appears.
- `fetch_err` stays set until reset and does not stop fetching.
- All outputs come directly from registers. There is no combinational path from inputs to outputs. `PC` drives instruction memory combinationally.
- The state machine is implicit: {RUN, BUBBLE}, tracked by `valid_D`.
  - RUN->BUBBLE on redirect.
  - BUBBLE->RUN on any non-stall cycle.
  - Both states hold on stall.

Test Plan:
- Reset then free-run with `RD`=`PC` ^ 32'hA5A5_0000, 4 cycles, `stall`=0. Expect:
  - `PC` = 0, 4, 8, 12.
  - From cycle 2, `instr_D` = `RD` of the previous `PC`, `PC_D` = previous `PC`, `valid_D`=1.
  - `fetch_count`=3 after cycle 4.
- Taken branch: `PC_D`=8, `valid_D`=1, `ImmOp`=-8, `PCsrc`=1. Expect:
  - Next `PC`=0, `valid_D`=0, `instr_D`=32'h13, `fetch_count` unchanged.
  - The following cycle delivers the instruction at 0 with `valid_D`=1.
- Stall: assert `stall` for 3 cycles at `PC`=16 with `PCsrc`=1. Expect:
  - `PC`, `instr_D`, `PC_D`, `valid_D` and `fetch_count` frozen; no redirect.
  - On release with `PCsrc` still 1, redirect to `PC_D`+`ImmOp`.
- Misaligned target: `PC_D`=4, `ImmOp`=6. Expect `PC`=8 and `fetch_err`=1, still set 10 cycles later; `rst` clears it.
- Wrap-around: force `PC`=32'hFFFF_FFFC via branch, run 2 cycles. Expect `PC`=0 and `PC_D`=32'hFFFF_FFFC.
- Reset mid-redirect: `rst`=1 and `PCsrc`=1 on the same edge. Expect `PC`=RESET_PC, `valid_D`=0, `fetch_count`=0, `fetch_err`=0.
